// File: rtl/sfu_accum_pkg.sv
// rtl/sfu_accum_pkg.sv - shared state encoding, default widths and lane post-processing helpers
package sfu_accum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int DEF_COL     = 8;
  localparam int DEF_PSUM_BW = 16;
  localparam int DEF_ACC_BW  = 24;
  localparam int DEF_DEPTH   = 16;

  // Post-processing runs on a fixed wide container so the helpers work for any lane width.
  localparam int MAX_W = 64;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic logic signed [MAX_W-1:0] relu_fn(input logic signed [MAX_W-1:0] v,
                                                      input logic en);
    return (en && (v < 0)) ? '0 : v;
  endfunction

  function automatic logic signed [MAX_W-1:0] sat_fn(input logic signed [MAX_W-1:0] v,
                                                     input int unsigned bw);
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    hi = $signed((MAX_W'(1) << (bw - 1)) - MAX_W'(1));
    lo = ~hi;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/sfu_lane_post.sv
// rtl/sfu_lane_post.sv - one lane of optional ReLU plus reduction from ACC_BW to PSUM_BW
// SFU_ACCUM_SAT_EN selects saturating reduction; otherwise the low PSUM_BW bits are kept.
module sfu_lane_post
  import sfu_accum_pkg::*;
#(
  parameter int ACC_BW  = DEF_ACC_BW,
  parameter int PSUM_BW = DEF_PSUM_BW
) (
  input  logic [ACC_BW-1:0]  acc_in,
  input  logic               relu_en,
  output logic [PSUM_BW-1:0] psum_out
);

  logic signed [MAX_W-1:0] wide;
  logic signed [MAX_W-1:0] rect;

  always_comb begin
    wide = MAX_W'($signed(acc_in));
    rect = relu_fn(wide, relu_en);
`ifdef SFU_ACCUM_SAT_EN
    psum_out = PSUM_BW'(sat_fn(rect, PSUM_BW));
`else
    psum_out = PSUM_BW'(rect);
`endif
  end

endmodule

// File: rtl/sfu_accum_bank.sv
// rtl/sfu_accum_bank.sv - multi-pass column partial-sum accumulation bank with ReLU drain
// SFU_ACCUM_SAT_EN (in sfu_lane_post) selects saturating output reduction.
module sfu_accum_bank
  import sfu_accum_pkg::*;
#(
  parameter int COL     = DEF_COL,
  parameter int PSUM_BW = DEF_PSUM_BW,
  parameter int ACC_BW  = DEF_ACC_BW,
  parameter int DEPTH   = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [7:0]             cfg_passes,
  input  logic                   cfg_relu_en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [COL*PSUM_BW-1:0] in_psum,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COL*PSUM_BW-1:0] out_data,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done
);

  localparam int AW = addr_w(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_e                 state_q, state_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [7:0]             pass_q, pass_d;
  logic [7:0]             passes_q, passes_d;
  logic                   relu_q, relu_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_last_q, out_last_d;
  logic [COL*PSUM_BW-1:0] out_data_q, out_data_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [COL*ACC_BW-1:0]  bank_q [DEPTH];
  logic [COL*ACC_BW-1:0]  rd_word;
  logic [COL*ACC_BW-1:0]  wr_word;
  logic [COL*PSUM_BW-1:0] post_word;
  logic                   wr_en;

  // One shared pointer serves both the accumulate write and the drain read.
  assign rd_word = bank_q[addr_q];
  assign wr_en   = (state_q == ST_ACCUM) && in_valid && in_ready_q;

  for (genvar i = 0; i < COL; i++) begin : g_lane
    logic signed [ACC_BW-1:0] in_ext;
    logic signed [ACC_BW-1:0] acc_old;

    assign in_ext  = ACC_BW'($signed(in_psum[i*PSUM_BW +: PSUM_BW]));
    assign acc_old = $signed(rd_word[i*ACC_BW +: ACC_BW]);
    // The first pass overwrites so leftovers from an earlier job never leak in.
    assign wr_word[i*ACC_BW +: ACC_BW] = (pass_q == 8'd0) ? in_ext : (acc_old + in_ext);

    sfu_lane_post #(
      .ACC_BW  (ACC_BW),
      .PSUM_BW (PSUM_BW)
    ) u_post (
      .acc_in   (rd_word[i*ACC_BW +: ACC_BW]),
      .relu_en  (relu_q),
      .psum_out (post_word[i*PSUM_BW +: PSUM_BW])
    );
  end

  always_ff @(posedge clk) begin
    if (wr_en) bank_q[addr_q] <= wr_word;
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pass_d      = pass_q;
    passes_d    = passes_q;
    relu_d      = relu_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          passes_d = (cfg_passes == 8'd0) ? 8'd1 : cfg_passes;
          relu_d   = cfg_relu_en;
          addr_d   = '0;
          pass_d   = 8'd0;
          state_d  = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (wr_en) begin
          if (addr_q == LAST_ADDR) begin
            addr_d = '0;
            if (pass_q == passes_q - 8'd1) begin
              pass_d  = 8'd0;
              state_d = ST_DRAIN;
            end else begin
              pass_d = pass_q + 8'd1;
            end
          end else begin
            addr_d = addr_q + AW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (out_valid_q && out_ready && out_last_q) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = ST_DONE;
        end else if (!out_valid_q || out_ready) begin
          // Output register is empty or being consumed: load the next entry.
          out_data_d  = post_word;
          out_valid_d = 1'b1;
          out_last_d  = (addr_q == LAST_ADDR);
          addr_d      = (addr_q == LAST_ADDR) ? '0 : addr_q + AW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d = (state_d == ST_ACCUM);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      pass_q      <= 8'd0;
      passes_q    <= 8'd0;
      relu_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      pass_q      <= pass_d;
      passes_q    <= passes_d;
      relu_q      <= relu_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sfu_accum_bank.sv
// tb/tb_sfu_accum_bank.sv - directed self-checking bench for sfu_accum_bank (COL=8, DEPTH=4)
module tb_sfu_accum_bank;

  localparam int COL     = 8;
  localparam int PSUM_BW = 16;
  localparam int ACC_BW  = 24;
  localparam int DEPTH   = 4;
  localparam int W       = COL * PSUM_BW;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [7:0]   cfg_passes;
  logic         cfg_relu_en;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_psum;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;
  logic         done;

  int checks;
  int errors;

  int           hs_timeout;
  int           beats;
  int           done_cnt;
  int           unstable;
  int           timeout;
  int           first_valid_cyc;
  int           last_hs_cyc;
  int           done_cyc;
  int           idle_cyc;
  logic [W-1:0] got_data [8];
  logic         got_last [8];

  sfu_accum_bank #(
    .COL     (COL),
    .PSUM_BW (PSUM_BW),
    .ACC_BW  (ACC_BW),
    .DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cfg_passes  (cfg_passes),
    .cfg_relu_en (cfg_relu_en),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_psum     (in_psum),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] splat(input logic [PSUM_BW-1:0] v);
    return {COL{v}};
  endfunction

  function automatic logic [W-1:0] mixed(input int e);
    logic [W-1:0] w;
    for (int i = 0; i < COL; i++) w[i*PSUM_BW +: PSUM_BW] = PSUM_BW'(e * 16 + i);
    return w;
  endfunction

  task automatic start_job(input logic [7:0] p, input logic r);
    @(negedge clk);
    start = 1'b1; cfg_passes = p; cfg_relu_en = r;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [W-1:0] d);
    in_valid = 1'b1;
    in_psum  = d;
    for (int k = 0; k < 20 && !in_ready; k++) @(negedge clk);
    if (!in_ready) hs_timeout++;
    @(negedge clk);
  endtask

  // Called on the first DRAIN negedge; records beats and timing for the caller to check.
  task automatic drain_capture(input int mode);
    logic         r;
    logic         holding;
    logic [W-1:0] hold_d;
    logic         hold_l;
    beats = 0; done_cnt = 0; unstable = 0; timeout = 1;
    first_valid_cyc = -1; last_hs_cyc = -1; done_cyc = -1; idle_cyc = -1;
    holding = 1'b0; hold_d = '0; hold_l = 1'b0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (holding && (out_valid !== 1'b1 || out_data !== hold_d || out_last !== hold_l)) unstable++;
      r = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      out_ready = r;
      if (out_valid && r) begin
        if (beats < 8) begin
          got_data[beats] = out_data;
          got_last[beats] = out_last;
        end
        beats++;
        last_hs_cyc = cyc;
      end
      holding = out_valid && !r;
      hold_d  = out_data;
      hold_l  = out_last;
      if (!busy && done_cyc >= 0 && idle_cyc < 0) idle_cyc = cyc;
      if (idle_cyc >= 0 && cyc >= idle_cyc + 3) begin
        timeout = 0;
        break;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_last, busy, done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b want=00000", {in_ready, out_valid, out_last, busy, done});
    end
    checks++;
    if (out_data !== '0) begin
      errors++;
      $display("FAIL reset_out_data got=%h want=0", out_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    hs_timeout = 0;
    start_job(8'd1, 1'b0);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_accum_entry got in_ready=%b busy=%b want 1 1", in_ready, busy);
    end
    for (int e = 0; e < DEPTH; e++) send_beat(splat(PSUM_BW'(e)));
    in_valid = 1'b0;
    drain_capture(0);
    checks++;
    if (timeout != 0 || hs_timeout != 0 || beats != 4) begin
      errors++;
      $display("FAIL basic_beats got=%0d timeout=%0d/%0d want 4 beats", beats, timeout, hs_timeout);
    end
    for (int b = 0; b < DEPTH; b++) begin
      checks++;
      if (got_data[b] !== splat(PSUM_BW'(b)) || got_last[b] !== (b == DEPTH - 1)) begin
        errors++;
        $display("FAIL basic_beat%0d got=%h last=%b want=%h last=%b",
                 b, got_data[b], got_last[b], splat(PSUM_BW'(b)), (b == DEPTH - 1));
      end
    end
    checks++;
    if (first_valid_cyc != 1 || last_hs_cyc != 4 || done_cyc != 5 || idle_cyc != 6) begin
      errors++;
      $display("FAIL basic_timing got valid=%0d last=%0d done=%0d idle=%0d want 1 4 5 6",
               first_valid_cyc, last_hs_cyc, done_cyc, idle_cyc);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL basic_done_pulses got=%0d want=1", done_cnt);
    end
  endtask

  task automatic test_relu_passes;
    for (int r = 1; r >= 0; r--) begin
      hs_timeout = 0;
      start_job(8'd3, r[0]);
      for (int k = 0; k < 3 * DEPTH; k++) send_beat(splat(16'hFFFB));
      in_valid = 1'b0;
      drain_capture(0);
      checks++;
      if (timeout != 0 || hs_timeout != 0 || beats != 4 || done_cnt != 1) begin
        errors++;
        $display("FAIL relu%0d_beats got=%0d done=%0d want 4 1", r, beats, done_cnt);
      end
      for (int b = 0; b < DEPTH; b++) begin
        checks++;
        if (got_data[b] !== (r ? splat(16'h0000) : splat(16'hFFF1))) begin
          errors++;
          $display("FAIL relu%0d_beat%0d got=%h want=%h", r, b, got_data[b],
                   (r ? splat(16'h0000) : splat(16'hFFF1)));
        end
      end
    end
  endtask

  task automatic test_width_reduce;
    logic [PSUM_BW-1:0] want;
`ifdef SFU_ACCUM_SAT_EN
    want = 16'h7FFF;
`else
    want = 16'hFA00;
`endif
    hs_timeout = 0;
    start_job(8'd4, 1'b0);
    for (int k = 0; k < 4 * DEPTH; k++) send_beat(splat(16'd16000));
    in_valid = 1'b0;
    drain_capture(0);
    checks++;
    if (timeout != 0 || hs_timeout != 0 || beats != 4) begin
      errors++;
      $display("FAIL reduce_beats got=%0d want=4", beats);
    end
    for (int b = 0; b < DEPTH; b++) begin
      checks++;
      if (got_data[b] !== splat(want)) begin
        errors++;
        $display("FAIL reduce_beat%0d got=%h want=%h", b, got_data[b], splat(want));
      end
    end
  endtask

  task automatic test_backpressure;
    hs_timeout = 0;
    start_job(8'd1, 1'b0);
    for (int e = 0; e < DEPTH; e++) send_beat(mixed(e));
    in_valid = 1'b0;
    drain_capture(1);
    checks++;
    if (timeout != 0 || beats != 4 || unstable != 0) begin
      errors++;
      $display("FAIL bp_flow got beats=%0d unstable=%0d want 4 0", beats, unstable);
    end
    for (int b = 0; b < DEPTH; b++) begin
      checks++;
      if (got_data[b] !== mixed(b) || got_last[b] !== (b == DEPTH - 1)) begin
        errors++;
        $display("FAIL bp_beat%0d got=%h last=%b want=%h", b, got_data[b], got_last[b], mixed(b));
      end
    end
    checks++;
    if (last_hs_cyc != 8 || done_cyc != 9 || done_cnt != 1) begin
      errors++;
      $display("FAIL bp_timing got last=%0d done=%0d cnt=%0d want 8 9 1", last_hs_cyc, done_cyc, done_cnt);
    end
  endtask

  task automatic test_reset_mid;
    hs_timeout = 0;
    start_job(8'd2, 1'b1);
    for (int k = 0; k < 5; k++) send_beat(splat(16'd100));
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy, done} !== 4'b0) begin
      errors++;
      $display("FAIL midreset_flags got=%b want=0000", {in_ready, out_valid, busy, done});
    end
    rst_n = 1'b1;
    start_job(8'd1, 1'b0);
    for (int e = 0; e < DEPTH; e++) send_beat(splat(PSUM_BW'(7 - e)) ^ mixed(e));
    in_valid = 1'b0;
    drain_capture(0);
    checks++;
    if (timeout != 0 || hs_timeout != 0 || beats != 4 || done_cnt != 1) begin
      errors++;
      $display("FAIL midreset_beats got=%0d done=%0d want 4 1", beats, done_cnt);
    end
    for (int b = 0; b < DEPTH; b++) begin
      checks++;
      if (got_data[b] !== (splat(PSUM_BW'(7 - b)) ^ mixed(b))) begin
        errors++;
        $display("FAIL midreset_beat%0d got=%h want=%h", b, got_data[b], splat(PSUM_BW'(7 - b)) ^ mixed(b));
      end
    end
  endtask

  task automatic test_passes_zero;
    hs_timeout = 0;
    start_job(8'd0, 1'b0);
    for (int e = 0; e < DEPTH; e++) begin
      if (e == 1) begin
        start = 1'b1; cfg_passes = 8'd5; cfg_relu_en = 1'b1;
      end
      send_beat(splat(PSUM_BW'(-(e + 1))));
      start = 1'b0;
    end
    in_valid = 1'b0;
    drain_capture(0);
    checks++;
    if (timeout != 0 || hs_timeout != 0 || beats != 4 || done_cnt != 1) begin
      errors++;
      $display("FAIL pass0_beats got=%0d done=%0d want 4 1", beats, done_cnt);
    end
    for (int b = 0; b < DEPTH; b++) begin
      checks++;
      if (got_data[b] !== splat(PSUM_BW'(-(b + 1)))) begin
        errors++;
        $display("FAIL pass0_beat%0d got=%h want=%h", b, got_data[b], splat(PSUM_BW'(-(b + 1))));
      end
    end
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL pass0_idle got busy=%b in_ready=%b want 0 0", busy, in_ready);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; start = 1'b0; cfg_passes = 8'd0; cfg_relu_en = 1'b0;
    in_valid = 1'b0; in_psum = '0; out_ready = 1'b0;
    test_reset;
    test_basic;
    test_relu_passes;
    test_width_reduce;
    test_backpressure;
    test_reset_mid;
    test_passes_zero;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
